// File: rtl/vga_line_fetcher.sv
// Ping-pong line buffer feeding vga_controller: the next visible line is fetched
// from the framebuffer over a req/ack port while the current one is scanned out.
module vga_line_fetcher #(
  parameter int          WIDTH    = 12,
  parameter int          HSIZE    = 800,
  parameter int          HMAX     = 1040,
  parameter int          VSIZE    = 600,
  parameter int          VMAX     = 666,
  parameter logic [18:0] FB_BASE  = 19'd0,
  parameter logic [31:0] UR_COLOR = 32'h00FF00FF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] hdata,
  input  logic [WIDTH-1:0] vdata,
  input  logic             data_enable,
  output logic [31:0]      pixel,
  output logic             mem_req,
  output logic [18:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             fetch_busy,
  output logic             underrun,
  input  logic             underrun_clr
);
  localparam int          XW    = (HSIZE > 1) ? $clog2(HSIZE) : 1;
  localparam int          CW    = $clog2(HMAX + 2) + 1;
  localparam logic [18:0] HSTEP = 19'(HSIZE);
  localparam logic [XW-1:0] XLAST = XW'(HSIZE - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic          tgt;
  logic [1:0]    bad;
  logic [18:0]   line_base;
  logic [CW-1:0] fetch_cnt;
  logic [31:0]   buf0 [HSIZE];
  logic [31:0]   buf1 [HSIZE];

  logic trig, trig_first, trig_tgt, ack_req, fetch_done, disp_chk, ur_set;

  always_comb begin
    trig_first = (vdata == WIDTH'(VMAX - 1));
    trig       = (hdata == '0) && (trig_first || (vdata < WIDTH'(VSIZE - 1)));
    trig_tgt   = trig_first ? 1'b0 : ~vdata[0];
    ack_req    = (state == REQ) && mem_ack;
    fetch_done = ack_req && (x == XLAST);
    disp_chk   = (hdata == '0) && (vdata < WIDTH'(VSIZE)) && bad[vdata[0]];
    // A fetch whose last word lands on the trigger cycle counts as complete.
    ur_set     = disp_chk || (trig && (state == REQ) && !fetch_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_busy <= 1'b0;
      underrun   <= 1'b0;
      bad        <= 2'b11;
      x          <= '0;
      tgt        <= 1'b0;
      line_base  <= FB_BASE;
      fetch_cnt  <= '0;
    end else begin
      if (ur_set)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
      if (fetch_cnt != '1)
        fetch_cnt <= fetch_cnt + 1'b1;
      if (ack_req) begin
        mem_addr <= mem_addr + 19'd1;
        x        <= x + 1'b1;
      end
      if (fetch_done) begin
        state      <= IDLE;
        mem_req    <= 1'b0;
        fetch_busy <= 1'b0;
        bad[tgt]   <= 1'b0;
      end
      // Trigger starts a fresh fetch, abandoning any fetch still in flight.
      if (trig) begin
        state         <= REQ;
        mem_req       <= 1'b1;
        fetch_busy    <= 1'b1;
        tgt           <= trig_tgt;
        x             <= '0;
        fetch_cnt     <= '0;
        bad[trig_tgt] <= 1'b1;
        if (trig_first) begin
          mem_addr  <= FB_BASE;
          line_base <= FB_BASE;
        end else begin
          mem_addr  <= line_base + HSTEP;
          line_base <= line_base + HSTEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ack_req) begin
      if (tgt)
        buf1[x] <= mem_rdata;
      else
        buf0[x] <= mem_rdata;
    end
  end

  always_comb begin
    pixel = '0;
    if (data_enable) begin
      if (bad[vdata[0]])
        pixel = UR_COLOR;
      else if (vdata[0])
        pixel = buf1[hdata[XW-1:0]];
      else
        pixel = buf0[hdata[XW-1:0]];
    end
  end

  // A fetch running longer than a line time must already have been flagged.
  always @(posedge clk) begin
    if (rst_n && (state == REQ) && (fetch_cnt > CW'(HMAX)))
      assert (underrun);
  end
endmodule

// File: tb/tb_vga_line_fetcher.sv
// Randomised bench for vga_line_fetcher: drives controller timing and a memory
// port, and checks every output each cycle against a line-level reference.
module tb_vga_line_fetcher;
  localparam int          WIDTH = 12;
  localparam int          HSIZE = 8;
  localparam int          HMAX  = 12;
  localparam int          VSIZE = 4;
  localparam int          VMAX  = 6;
  localparam logic [18:0] FB    = 19'd100;
  localparam logic [31:0] UR    = 32'h00FF00FF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] hdata = '0;
  logic [WIDTH-1:0] vdata = '0;
  logic             data_enable = 1'b0;
  logic [31:0]      pixel;
  logic             mem_req;
  logic [18:0]      mem_addr;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_rdata;
  logic             fetch_busy;
  logic             underrun;
  logic             underrun_clr = 1'b0;

  vga_line_fetcher #(
    .WIDTH(WIDTH), .HSIZE(HSIZE), .HMAX(HMAX), .VSIZE(VSIZE), .VMAX(VMAX),
    .FB_BASE(FB), .UR_COLOR(UR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata),
    .data_enable(data_enable), .pixel(pixel), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fetch_busy(fetch_busy), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  // Memory returns its own word address as data.
  assign mem_rdata = {13'd0, mem_addr};

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int        cnt_h, cnt_v, mode;
  bit        clr_req, rst_drive, tog;
  bit [11:0] mask;

  // Reference state: which line is being fetched, words received so far,
  // per-parity validity and the sticky flag.
  bit       m_act, m_under, m_zero;
  int       m_line, m_cnt;
  bit [1:0] m_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s v=%0d h=%0d: got %h expected %h", name, vdata, hdata, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_under = 0; m_zero = 1; m_line = 0; m_cnt = 0; m_bad = 2'b11;
  endtask

  function automatic logic [31:0] exp_pixel(input int v, input int h);
    if (!(h < HSIZE && v < VSIZE)) return 32'd0;
    if (m_bad[v % 2]) return UR;
    return 32'(FB) + 32'(v * HSIZE + h);
  endfunction

  function automatic logic [18:0] exp_addr();
    if (m_zero) return 19'd0;
    return 19'(int'(FB) + m_line * HSIZE + m_cnt);
  endfunction

  task automatic model_update(input int v, input int h, input bit ack, input bit clr);
    bit set, done, trig;
    int nl;
    trig = (h == 0) && (v == VMAX - 1 || v < VSIZE - 1);
    nl   = (v == VMAX - 1) ? 0 : v + 1;
    set  = (h == 0) && (v < VSIZE) && m_bad[v % 2];
    done = m_act && ack && (m_cnt == HSIZE - 1);
    if (m_act && ack) m_cnt++;
    if (done) begin
      m_act = 0;
      m_bad[m_line % 2] = 0;
    end
    if (trig) begin
      if (m_act) set = 1;
      m_act = 1; m_line = nl; m_cnt = 0; m_bad[nl % 2] = 1; m_zero = 0;
    end
    if (set) m_under = 1;
    else if (clr) m_under = 0;
  endtask

  // Eight acks guaranteed in positions 1..11 so a fetch fits in one line time.
  function automatic bit [11:0] new_mask();
    bit [11:0] m;
    int z, p;
    m = 12'hFFF;
    m[0] = 1'($urandom_range(0, 1));
    z = 0;
    while (z < 3) begin
      p = $urandom_range(1, 11);
      if (m[p]) begin
        m[p] = 1'b0;
        z++;
      end
    end
    return m;
  endfunction

  task automatic cycle();
    bit ack;
    @(posedge clk);
    #1;
    rst_n       = rst_drive;
    hdata       = WIDTH'(cnt_h);
    vdata       = WIDTH'(cnt_v);
    data_enable = (cnt_h < HSIZE) && (cnt_v < VSIZE);
    if (cnt_h == 0) mask = new_mask();
    case (mode)
      0:       ack = 1'b1;
      1:       begin tog = ~tog; ack = tog; end
      default: ack = mask[cnt_h];
    endcase
    mem_ack      = ack;
    underrun_clr = clr_req;
    clr_req      = 0;
    @(negedge clk);
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_act});
    chk("mem_addr", {13'd0, mem_addr}, {13'd0, exp_addr()});
    chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, m_act});
    chk("underrun", {31'd0, underrun}, {31'd0, m_under});
    chk("pixel", pixel, exp_pixel(cnt_v, cnt_h));
    if (rst_n) model_update(cnt_v, cnt_h, ack, underrun_clr);
    cnt_h++;
    if (cnt_h == HMAX) begin
      cnt_h = 0;
      cnt_v = (cnt_v == VMAX - 1) ? 0 : cnt_v + 1;
    end
  endtask

  task automatic goto(input int v, input int h);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(int'(vdata) == v && int'(hdata) == h) && n < HMAX * VMAX + 2);
    chk("goto_reached", {31'd0, (int'(vdata) == v && int'(hdata) == h)}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mode = 0; rst_drive = 0; clr_req = 0; tog = 0; mask = 12'hFFF;
    cnt_h = 0; cnt_v = 0;
    model_reset();
    repeat (3) cycle();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);

    // Ack always high: clean frames, literal pixel/address points.
    cnt_v = VMAX - 1; cnt_h = 0; rst_drive = 1;
    repeat (2 * HMAX * VMAX) cycle();
    goto(0, 0);
    chk("lit_px_0_0", pixel, 32'd100);
    chk("lit_addr_0_0", {13'd0, mem_addr}, 32'd108);
    goto(1, 2);
    chk("lit_px_1_2", pixel, 32'd110);
    goto(3, 1);
    chk("lit_busy_3", {31'd0, fetch_busy}, 32'd0);
    goto(3, 7);
    chk("lit_px_3_7", pixel, 32'd131);
    chk("lit_addr_end", {13'd0, mem_addr}, 32'd132);
    goto(4, 1);
    chk("lit_busy_4", {31'd0, fetch_busy}, 32'd0);
    goto(4, 9);
    chk("lit_px_vblank", pixel, 32'd0);
    goto(0, 9);
    chk("lit_px_hblank", pixel, 32'd0);
    chk("lit_ur_clean", {31'd0, underrun}, 32'd0);

    // Random ack with enough bandwidth per line.
    mode = 2;
    repeat (4 * HMAX * VMAX) cycle();
    chk("lit_ur_random", {31'd0, underrun}, 32'd0);

    // Ack every other clock: every fetch overruns.
    mode = 1;
    repeat (2 * HMAX * VMAX) cycle();
    goto(2, 3);
    chk("lit_px_slow", pixel, UR);
    chk("lit_ur_slow", {31'd0, underrun}, 32'd1);

    // Clear alone, then clear colliding with a set.
    goto(1, 4);
    clr_req = 1;
    goto(1, 6);
    chk("lit_ur_cleared", {31'd0, underrun}, 32'd0);
    goto(1, 11);
    clr_req = 1;
    goto(2, 0);
    cycle();
    chk("lit_ur_set_wins", {31'd0, underrun}, 32'd1);

    // Restore bandwidth, clear in vblank, flag stays low afterwards.
    mode = 0;
    goto(VMAX - 1, 0);
    repeat (HMAX * VMAX) cycle();
    goto(VSIZE, 2);
    clr_req = 1;
    repeat (2 * HMAX * VMAX) cycle();
    chk("lit_ur_after_clr", {31'd0, underrun}, 32'd0);

    // Asynchronous reset in the middle of a fetch.
    goto(0, 4);
    #2;
    rst_n = 0; rst_drive = 0;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_busy", {31'd0, fetch_busy}, 32'd0);
    chk("async_addr", {13'd0, mem_addr}, 32'd0);
    chk("async_underrun", {31'd0, underrun}, 32'd0);
    model_reset();
    repeat (3) cycle();
    cnt_v = 0; cnt_h = 0; rst_drive = 1;
    goto(0, 2);
    chk("lit_px_after_rst", pixel, UR);
    chk("lit_ur_after_rst", {31'd0, underrun}, 32'd1);
    goto(1, 3);
    chk("lit_px_line1_rst", pixel, 32'd111);
    repeat (2 * HMAX * VMAX) cycle();
    goto(0, 5);
    chk("lit_px_recovered", pixel, 32'd105);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
